// File: rtl/coeff_bank_sequencer.sv
// coeff_bank_sequencer: streams a CPU-staged coefficient set into one axis/bank of
// the 3-axis FIR through its update port, then optionally swaps that axis's active
// bank on the next sample boundary. Owns the x/y/z active bank-select registers.
module coeff_bank_sequencer #(
    parameter int TAPS    = 16,
    parameter int COEFF_W = 16,
    parameter int GAP     = 0,
    localparam int IDX_W  = $clog2(TAPS)
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               stage_we,
    input  logic [IDX_W-1:0]   stage_index,
    input  logic [COEFF_W-1:0] stage_value,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_axis,
    input  logic [1:0]         cmd_bank,
    input  logic               cmd_activate,
    input  logic               sample_strobe,
    output logic               update_en,
    output logic [1:0]         update_axis,
    output logic [1:0]         update_bank,
    output logic [IDX_W-1:0]   update_index,
    output logic [COEFF_W-1:0] update_value,
    output logic [1:0]         x_bank,
    output logic [1:0]         y_bank,
    output logic [1:0]         z_bank,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_SWAP, DONE} state_t;

    localparam logic [3:0]       GAP_L    = 4'(GAP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    state_t             state_reg;
    logic               cmd_ready_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               err_reg;
    logic               upd_en_reg;
    logic [1:0]         upd_axis_reg;
    logic [1:0]         upd_bank_reg;
    logic [IDX_W-1:0]   upd_index_reg;
    logic [COEFF_W-1:0] upd_value_reg;
    logic [1:0]         x_bank_reg;
    logic [1:0]         y_bank_reg;
    logic [1:0]         z_bank_reg;
    logic [1:0]         axis_reg;
    logic [1:0]         bank_reg;
    logic               act_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [3:0]         gap_reg;
    logic [1:0]         cur_bank;

    // Staging buffer; cleared by reset so a reset really discards a half-set load
    logic [COEFF_W-1:0] stage_mem [TAPS];
    logic [TAPS-1:0]    stage_hit;

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_stage_hit
            // Writes are only honoured while idle so an in-flight load is never disturbed
            assign stage_hit[gi] = stage_we && (state_reg == IDLE) && (stage_index == IDX_W'(gi));
        end
    endgenerate

    // Staging entry writes
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) stage_mem[i] <= '0;
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                if (stage_hit[i]) stage_mem[i] <= stage_value;
            end
        end
    end

    // Currently active bank of the axis named by the incoming command
    always_comb begin
        cur_bank = 2'd0;
        case (cmd_axis)
            2'd0:    cur_bank = x_bank_reg;
            2'd1:    cur_bank = y_bank_reg;
            2'd2:    cur_bank = z_bank_reg;
            default: cur_bank = 2'd0;
        endcase
    end

    // Command sequencing FSM with registered outputs
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            upd_en_reg    <= 1'b0;
            upd_axis_reg  <= 2'd0;
            upd_bank_reg  <= 2'd0;
            upd_index_reg <= '0;
            upd_value_reg <= '0;
            x_bank_reg    <= 2'd0;
            y_bank_reg    <= 2'd0;
            z_bank_reg    <= 2'd0;
            axis_reg      <= 2'd0;
            bank_reg      <= 2'd0;
            act_reg       <= 1'b0;
            idx_reg       <= '0;
            gap_reg       <= 4'd0;
        end else begin
            // Pulses and the update bus default to zero every cycle
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            upd_en_reg    <= 1'b0;
            upd_axis_reg  <= 2'd0;
            upd_bank_reg  <= 2'd0;
            upd_index_reg <= '0;
            upd_value_reg <= '0;
            case (state_reg)
                IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (cmd_valid && cmd_ready_reg) begin
                        axis_reg <= cmd_axis;
                        bank_reg <= cmd_bank;
                        act_reg  <= cmd_activate;
                        // Writing into the live bank would corrupt the running filter
                        if (cmd_axis == 2'd3 || cmd_bank == cur_bank) begin
                            err_reg <= 1'b1;
                        end else begin
                            state_reg     <= WRITE;
                            busy_reg      <= 1'b1;
                            cmd_ready_reg <= 1'b0;
                            idx_reg       <= '0;
                            gap_reg       <= 4'd0;
                        end
                    end
                end
                WRITE: begin
                    if (gap_reg == 4'd0) begin
                        upd_en_reg    <= 1'b1;
                        upd_axis_reg  <= axis_reg;
                        upd_bank_reg  <= bank_reg;
                        upd_index_reg <= idx_reg;
                        upd_value_reg <= stage_mem[idx_reg];
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= act_reg ? WAIT_SWAP : DONE;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                            gap_reg <= GAP_L;
                        end
                    end else begin
                        gap_reg <= gap_reg - 4'd1;
                    end
                end
                WAIT_SWAP: begin
                    // Swap only on a sample boundary so the filter never sees a mid-sample change
                    if (sample_strobe) begin
                        case (axis_reg)
                            2'd0:    x_bank_reg <= bank_reg;
                            2'd1:    y_bank_reg <= bank_reg;
                            default: z_bank_reg <= bank_reg;
                        endcase
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign err          = err_reg;
    assign update_en    = upd_en_reg;
    assign update_axis  = upd_axis_reg;
    assign update_bank  = upd_bank_reg;
    assign update_index = upd_index_reg;
    assign update_value = upd_value_reg;
    assign x_bank       = x_bank_reg;
    assign y_bank       = y_bank_reg;
    assign z_bank       = z_bank_reg;

endmodule

// File: tb/tb_coeff_bank_sequencer.sv
// Testbench for coeff_bank_sequencer: queue-based scoreboard fed by the stimulus
// driver, with an independent negedge monitor, plus a second GAP=2 instance.
module tb_coeff_bank_sequencer;

    localparam int TAPS    = 16;
    localparam int COEFF_W = 16;
    localparam int IDX_W   = 4;
    localparam int GAP     = 0;
    localparam int GAP2    = 2;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic               rst = 1'b1;
    logic               stage_we = 1'b0;
    logic [IDX_W-1:0]   stage_index = '0;
    logic [COEFF_W-1:0] stage_value = '0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_axis = 2'd0;
    logic [1:0]         cmd_bank = 2'd0;
    logic               cmd_activate = 1'b0;
    logic               sample_strobe = 1'b0;
    logic               update_en;
    logic [1:0]         update_axis, update_bank;
    logic [IDX_W-1:0]   update_index;
    logic [COEFF_W-1:0] update_value;
    logic [1:0]         x_bank, y_bank, z_bank;
    logic               busy, done, err;

    // Second instance built with GAP=2
    logic               g_stage_we = 1'b0;
    logic [IDX_W-1:0]   g_stage_index = '0;
    logic [COEFF_W-1:0] g_stage_value = '0;
    logic               g_cmd_valid = 1'b0;
    logic               g_cmd_ready;
    logic [1:0]         g_cmd_axis = 2'd0;
    logic [1:0]         g_cmd_bank = 2'd0;
    logic               g_update_en;
    logic [1:0]         g_update_axis, g_update_bank;
    logic [IDX_W-1:0]   g_update_index;
    logic [COEFF_W-1:0] g_update_value;
    logic [1:0]         g_x_bank, g_y_bank, g_z_bank;
    logic               g_busy, g_done, g_err;

    coeff_bank_sequencer #(.TAPS(TAPS), .COEFF_W(COEFF_W), .GAP(GAP)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .stage_we(stage_we), .stage_index(stage_index), .stage_value(stage_value),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_axis(cmd_axis),
        .cmd_bank(cmd_bank), .cmd_activate(cmd_activate), .sample_strobe(sample_strobe),
        .update_en(update_en), .update_axis(update_axis), .update_bank(update_bank),
        .update_index(update_index), .update_value(update_value),
        .x_bank(x_bank), .y_bank(y_bank), .z_bank(z_bank),
        .busy(busy), .done(done), .err(err)
    );

    coeff_bank_sequencer #(.TAPS(TAPS), .COEFF_W(COEFF_W), .GAP(GAP2)) dut_gap (
        .sys_clk(sys_clk), .rst(rst),
        .stage_we(g_stage_we), .stage_index(g_stage_index), .stage_value(g_stage_value),
        .cmd_valid(g_cmd_valid), .cmd_ready(g_cmd_ready), .cmd_axis(g_cmd_axis),
        .cmd_bank(g_cmd_bank), .cmd_activate(1'b0), .sample_strobe(1'b0),
        .update_en(g_update_en), .update_axis(g_update_axis), .update_bank(g_update_bank),
        .update_index(g_update_index), .update_value(g_update_value),
        .x_bank(g_x_bank), .y_bank(g_y_bank), .z_bank(g_z_bank),
        .busy(g_busy), .done(g_done), .err(g_err)
    );

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int cyc;
        int axis;
        int bank;
        int index;
        int value;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  exp_err[$];
    int  model_stage[TAPS];
    int  model_bank[3];

    wr_t g_log[$];
    int  g_done_cyc = -1;
    int  g_model[TAPS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s cycle=%0d", name, cyc);
    endtask

    // Monitor: compares every DUT output cycle against the scoreboard queues
    always @(negedge sys_clk) begin
        wr_t e;
        int  ec;
        check("x_bank", x_bank, model_bank[0]);
        check("y_bank", y_bank, model_bank[1]);
        check("z_bank", z_bank, model_bank[2]);
        if (update_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                flag("unexpected_update_en");
            end else begin
                e = exp_wr.pop_front();
                $display("write cycle=%0d axis=%0d bank=%0d index=%0d value=%04h", cyc,
                         update_axis, update_bank, update_index, update_value);
                check("write_cycle", cyc, e.cyc);
                check("update_axis", update_axis, e.axis);
                check("update_bank", update_bank, e.bank);
                check("update_index", update_index, e.index);
                check("update_value", update_value, e.value);
            end
        end else begin
            check("idle_update_bus", {update_axis, update_bank, update_index, update_value}, 0);
            if (exp_wr.size() > 0 && cyc > exp_wr[0].cyc) begin
                e = exp_wr.pop_front();
                flag("missing_update_en");
            end
        end
        if (done === 1'b1) begin
            if (exp_done.size() == 0) flag("unexpected_done");
            else begin
                ec = exp_done.pop_front();
                $display("done cycle=%0d x=%0d y=%0d z=%0d", cyc, x_bank, y_bank, z_bank);
                check("done_cycle", cyc, ec);
            end
        end else if (exp_done.size() > 0 && cyc > exp_done[0]) begin
            ec = exp_done.pop_front();
            flag("missing_done");
        end
        if (err === 1'b1) begin
            if (exp_err.size() == 0) flag("unexpected_err");
            else begin
                ec = exp_err.pop_front();
                $display("err cycle=%0d", cyc);
                check("err_cycle", cyc, ec);
            end
        end else if (exp_err.size() > 0 && cyc > exp_err[0]) begin
            ec = exp_err.pop_front();
            flag("missing_err");
        end
    end

    // Logger for the GAP=2 instance
    always @(negedge sys_clk) begin
        wr_t e;
        if (g_update_en === 1'b1) begin
            e.cyc   = cyc;
            e.axis  = int'(g_update_axis);
            e.bank  = int'(g_update_bank);
            e.index = int'(g_update_index);
            e.value = int'(g_update_value);
            g_log.push_back(e);
        end
        if (g_done === 1'b1) g_done_cyc = cyc;
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic stage_write(input int idx, input int val);
        stage_we    = 1'b1;
        stage_index = IDX_W'(idx);
        stage_value = COEFF_W'(val);
        model_stage[idx] = val;
        step();
        stage_we = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        if (cmd_ready !== 1'b1) flag("cmd_ready_timeout");
    endtask

    // Issue one command and drive it to completion; expectations come from the model
    task automatic run_cmd(input int axis, input int bank, input bit act, input int delay,
                           input bit poke, input bit same_stage);
        int  t, last, done_cyc, k, v;
        bit  legal, first;
        wr_t e;
        wait_ready();
        cmd_valid    = 1'b1;
        cmd_axis     = 2'(axis);
        cmd_bank     = 2'(bank);
        cmd_activate = act;
        if (same_stage) begin
            k = $urandom_range(0, TAPS - 1);
            v = $urandom_range(0, 65535);
            stage_we    = 1'b1;
            stage_index = IDX_W'(k);
            stage_value = COEFF_W'(v);
            model_stage[k] = v;
        end
        t = cyc + 1;
        legal = 1'b0;
        if (axis != 3) legal = (bank != model_bank[axis]);
        last = t + 1 + (TAPS - 1) * (GAP + 1);
        $display("cmd cycle=%0d axis=%0d bank=%0d activate=%0d legal=%0d", t, axis, bank, act, legal);
        if (!legal) begin
            exp_err.push_back(t);
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                e.cyc   = t + 1 + i * (GAP + 1);
                e.axis  = axis;
                e.bank  = bank;
                e.index = i;
                e.value = model_stage[i];
                exp_wr.push_back(e);
            end
        end
        step();
        cmd_valid = 1'b0;
        stage_we  = 1'b0;
        if (!legal) begin
            check("ready_after_reject", cmd_ready, 1);
            check("busy_after_reject", busy, 0);
            return;
        end
        first = 1'b1;
        while (cyc < last) begin
            check("busy_in_write", busy, 1);
            check("ready_in_write", cmd_ready, 0);
            if (poke) begin
                stage_we    = first ? 1'b1 : 1'($urandom_range(0, 1));
                stage_index = first ? IDX_W'(5) : IDX_W'($urandom_range(0, TAPS - 1));
                stage_value = COEFF_W'($urandom_range(0, 65535));
            end
            first = 1'b0;
            // Strobes while writing, including the final write edge, must be ignored
            sample_strobe = (cyc == last - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
        end
        stage_we      = 1'b0;
        sample_strobe = 1'b0;
        if (act) begin
            repeat (delay) begin
                check("busy_wait_swap", busy, 1);
                step();
            end
            sample_strobe = 1'b1;
            step();
            sample_strobe = 1'b0;
            model_bank[axis] = bank;
            done_cyc = cyc + 1;
        end else begin
            done_cyc = last + 1;
        end
        exp_done.push_back(done_cyc);
        k = 0;
        while (cyc < done_cyc && k < 100) begin
            step();
            k++;
        end
        check("ready_in_done_cycle", cmd_ready, 0);
        check("busy_in_done_cycle", busy, 0);
        step();
        check("ready_after_done", cmd_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int  t, c, ax, bk;
        wr_t e;
        for (int i = 0; i < TAPS; i++) model_stage[i] = 0;
        for (int i = 0; i < 3; i++) model_bank[i] = 0;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check("reset_outputs", {cmd_ready, update_en, busy, done, err, x_bank, y_bank, z_bank}, 0);
        rst = 1'b0;
        check("ready_at_release", cmd_ready, 0);
        step();
        check("ready_after_release", cmd_ready, 1);

        // Rejections: live bank and illegal axis
        run_cmd(0, 0, 1'b0, 0, 1'b0, 1'b0);
        run_cmd(3, 1, 1'b0, 0, 1'b0, 1'b0);

        // Plain load into y bank 2
        for (int i = 0; i < TAPS; i++) stage_write(i, 'h1000 + i);
        run_cmd(1, 2, 1'b0, 0, 1'b0, 1'b0);

        // Load with activate: strobe held off 20 cycles after the writes
        run_cmd(0, 1, 1'b1, 20, 1'b0, 1'b0);

        // Staging writes during a load are ignored by the next load
        run_cmd(2, 3, 1'b0, 0, 1'b1, 1'b0);
        run_cmd(2, 1, 1'b0, 0, 1'b0, 1'b0);

        // Randomised commands
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 4)) stage_write($urandom_range(0, TAPS - 1), $urandom_range(0, 65535));
            run_cmd($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Make sure some bank is nonzero, then reset in the middle of a stream
        if (model_bank[0] == 0 && model_bank[1] == 0 && model_bank[2] == 0)
            run_cmd(0, 2, 1'b1, 1, 1'b0, 1'b0);
        wait_ready();
        ax = 1;
        bk = (model_bank[1] + 1) % 4;
        cmd_valid = 1'b1;
        cmd_axis  = 2'(ax);
        cmd_bank  = 2'(bk);
        cmd_activate = 1'b1;
        t = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            e.cyc = t + 1 + i * (GAP + 1);
            e.axis = ax;
            e.bank = bk;
            e.index = i;
            e.value = model_stage[i];
            exp_wr.push_back(e);
        end
        step();
        cmd_valid = 1'b0;
        c = t + 1 + 7 * (GAP + 1);
        while (cyc < c) step();
        @(negedge sys_clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < TAPS; i++) model_stage[i] = 0;
        for (int i = 0; i < 3; i++) model_bank[i] = 0;
        #1;
        $display("reset mid-stream cycle=%0d", cyc);
        check("midreset_update_en", update_en, 0);
        check("midreset_banks", {x_bank, y_bank, z_bank}, 0);
        check("midreset_busy", busy, 0);
        check("midreset_ready", cmd_ready, 0);
        step();
        step();
        rst = 1'b0;
        step();
        check("ready_after_midreset", cmd_ready, 1);
        // Staging was cleared, so this load streams zeros
        run_cmd(0, 2, 1'b0, 0, 1'b0, 1'b0);

        // GAP=2 instance
        for (int i = 0; i < TAPS; i++) begin
            g_model[i]    = $urandom_range(0, 65535);
            g_stage_we    = 1'b1;
            g_stage_index = IDX_W'(i);
            g_stage_value = COEFF_W'(g_model[i]);
            step();
        end
        g_stage_we = 1'b0;
        check("gap_ready", g_cmd_ready, 1);
        g_cmd_valid = 1'b1;
        g_cmd_axis  = 2'd2;
        g_cmd_bank  = 2'd1;
        t = cyc + 1;
        step();
        g_cmd_valid = 1'b0;
        c = 0;
        while (g_done_cyc < 0 && c < 120) begin
            step();
            c++;
        end
        check("gap_write_count", g_log.size(), TAPS);
        if (g_log.size() == TAPS) begin
            check("gap_first_cycle", g_log[0].cyc, t + 1);
            check("gap_span", g_log[TAPS-1].cyc - g_log[0].cyc, (TAPS - 1) * (GAP2 + 1));
            for (int i = 0; i < TAPS; i++) begin
                $display("gap write cycle=%0d index=%0d value=%04h", g_log[i].cyc, g_log[i].index, g_log[i].value);
                check("gap_index", g_log[i].index, i);
                check("gap_value", g_log[i].value, g_model[i]);
                check("gap_axis_bank", {g_log[i].axis, g_log[i].bank}, {32'd2, 32'd1});
                if (i > 0) check("gap_spacing", g_log[i].cyc - g_log[i-1].cyc, GAP2 + 1);
            end
            check("gap_done_cycle", g_done_cyc, g_log[TAPS-1].cyc + 1);
        end
        check("gap_z_bank_unchanged", g_z_bank, 0);

        repeat (3) step();
        check("pending_writes", exp_wr.size(), 0);
        check("pending_done", exp_done.size(), 0);
        check("pending_err", exp_err.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
